// File: rtl/fx2_byte_packetizer.sv
// Drains bytes from the DAQ FIFO into an FX2 slave-FIFO endpoint, one SLWR strobe per byte.
// Full packets are auto-committed by the FX2; short packets are closed with PKTEND on idle timeout or disable.
module fx2_byte_packetizer #(
    parameter int unsigned PKT_BYTES      = 512,
    parameter int unsigned CNT_W          = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 13
) (
    input  logic             rdclk,
    input  logic             PresetFull,
    input  logic             enable,
    input  logic [7:0]       fifo_q,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    input  logic             fx2_full_n,
    output logic [7:0]       fx2_fd,
    output logic             fx2_slwr_n,
    output logic             fx2_pktend_n,
    output logic [CNT_W-1:0] byte_count,
    output logic [15:0]      pkt_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        STROBE = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             rdreq_q, rdreq_d;
    logic [7:0]       fd_q, fd_d;
    logic             slwr_n_q, slwr_n_d;
    logic             pktend_n_q, pktend_n_d;
    logic [CNT_W-1:0] bc_q, bc_d;
    logic [15:0]      pc_q, pc_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             busy_q, busy_d;
    logic             flush_req;

    // State and output registers
    always_ff @(posedge rdclk or posedge PresetFull) begin
        if (PresetFull) begin
            state_q    <= IDLE;
            rdreq_q    <= 1'b0;
            fd_q       <= 8'd0;
            slwr_n_q   <= 1'b1;
            pktend_n_q <= 1'b1;
            bc_q       <= '0;
            pc_q       <= 16'd0;
            to_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdreq_q    <= rdreq_d;
            fd_q       <= fd_d;
            slwr_n_q   <= slwr_n_d;
            pktend_n_q <= pktend_n_d;
            bc_q       <= bc_d;
            pc_q       <= pc_d;
            to_q       <= to_d;
            busy_q     <= busy_d;
        end
    end

    // A short packet is closed only when it holds data, so no zero-length packets.
    assign flush_req = (bc_q != '0) && ((to_q == TO_LIMIT) || !enable);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        rdreq_d    = 1'b0;
        fd_d       = fd_q;
        slwr_n_d   = 1'b1;
        pktend_n_d = 1'b1;
        bc_d       = bc_q;
        pc_d       = pc_q;
        to_d       = to_q;

        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (enable && !fifo_empty && fx2_full_n) begin
                    state_d = FETCH;
                    rdreq_d = 1'b1;
                end else if ((bc_q != '0) && fifo_empty && (to_q < TO_LIMIT)) begin
                    to_d = to_q + TO_W'(1);
                end
            end
            FETCH: state_d = LATCH;
            // FIFO read data is valid the cycle after the pop.
            LATCH: begin
                fd_d    = fifo_q;
                state_d = STROBE;
            end
            STROBE: begin
                if (fx2_full_n) begin
                    slwr_n_d = 1'b0;
                    to_d     = '0;
                    state_d  = IDLE;
                    if (bc_q == LAST_BYTE) begin
                        bc_d = '0;
                        pc_d = pc_q + 16'd1;
                    end else begin
                        bc_d = bc_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (fx2_full_n) begin
                    pktend_n_d = 1'b0;
                    bc_d       = '0;
                    pc_d       = pc_q + 16'd1;
                    to_d       = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bc_q == '0) begin
            to_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    assign fifo_rdreq   = rdreq_q;
    assign fx2_fd       = fd_q;
    assign fx2_slwr_n   = slwr_n_q;
    assign fx2_pktend_n = pktend_n_q;
    assign byte_count   = bc_q;
    assign pkt_count    = pc_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fx2_byte_packetizer.sv
// Directed bench for fx2_byte_packetizer with PKT_BYTES=4, TIMEOUT_CYCLES=8.
// A small FIFO model feeds bytes; a negedge monitor logs every strobe and packet end.
module tb_fx2_byte_packetizer;

    localparam int unsigned PKT_BYTES      = 4;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam int unsigned TO_W           = 4;

    logic             rdclk;
    logic             PresetFull;
    logic             enable;
    logic [7:0]       fifo_q;
    logic             fifo_empty;
    logic             fifo_rdreq;
    logic             fx2_full_n;
    logic [7:0]       fx2_fd;
    logic             fx2_slwr_n;
    logic             fx2_pktend_n;
    logic [CNT_W-1:0] byte_count;
    logic [15:0]      pkt_count;
    logic             busy;

    fx2_byte_packetizer #(
        .PKT_BYTES(PKT_BYTES), .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)
    ) dut (
        .rdclk(rdclk), .PresetFull(PresetFull), .enable(enable),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
        .fx2_full_n(fx2_full_n), .fx2_fd(fx2_fd), .fx2_slwr_n(fx2_slwr_n),
        .fx2_pktend_n(fx2_pktend_n), .byte_count(byte_count),
        .pkt_count(pkt_count), .busy(busy)
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    // FIFO model: registered read data, one cycle after the accepted pop
    logic [7:0]  mem [0:63];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    initial fifo_q = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge rdclk) begin
        if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
            fifo_q <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Bus monitor
    int         cyc = 0;
    int         slwr_cnt = 0;
    int         pktend_cnt = 0;
    int         rdreq_cnt = 0;
    int         bad_rdreq = 0;
    int         pktend_cyc = 0;
    logic [7:0] log_fd [0:63];
    logic [2:0] log_bc [0:63];
    logic [15:0] log_pc [0:63];
    int         log_cyc [0:63];

    always @(negedge rdclk) begin
        cyc <= cyc + 1;
        if (!PresetFull) begin
            if (!fx2_slwr_n) begin
                log_fd[slwr_cnt % 64]  <= fx2_fd;
                log_bc[slwr_cnt % 64]  <= byte_count;
                log_pc[slwr_cnt % 64]  <= pkt_count;
                log_cyc[slwr_cnt % 64] <= cyc;
                slwr_cnt <= slwr_cnt + 1;
            end
            if (!fx2_pktend_n) begin
                pktend_cnt <= pktend_cnt + 1;
                pktend_cyc <= cyc;
            end
            if (fifo_rdreq) rdreq_cnt <= rdreq_cnt + 1;
            if (fifo_rdreq && fifo_empty) bad_rdreq <= bad_rdreq + 1;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0:       return slwr_cnt;
            1:       return pktend_cnt;
            default: return rdreq_cnt;
        endcase
    endfunction

    task automatic wait_cnt(input string name, input int which, input int target, input int bound);
        int n = 0;
        while ((get_cnt(which) < target) && (n < bound)) begin
            @(negedge rdclk);
            #1;
            n++;
        end
        chk(name, 32'(get_cnt(which) >= target), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [2:0]  exp_bc;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs [0:5];
    int   s0, r0, p0, gap;
    logic held_ok;

    initial begin
        // Byte sequence spanning one auto-committed packet plus a 2-byte short packet
        vecs[0] = '{8'h01, 3'd1, 16'd2};
        vecs[1] = '{8'h02, 3'd2, 16'd2};
        vecs[2] = '{8'h03, 3'd3, 16'd2};
        vecs[3] = '{8'h04, 3'd0, 16'd3};
        vecs[4] = '{8'h05, 3'd1, 16'd3};
        vecs[5] = '{8'h06, 3'd2, 16'd3};

        PresetFull = 1'b1;
        enable     = 1'b0;
        fx2_full_n = 1'b1;
        repeat (3) @(negedge rdclk);
        chk("rst_rdreq",  32'(fifo_rdreq),   32'd0);
        chk("rst_slwr",   32'(fx2_slwr_n),   32'd1);
        chk("rst_pktend", 32'(fx2_pktend_n), 32'd1);
        chk("rst_fd",     32'(fx2_fd),       32'd0);
        chk("rst_bc",     32'(byte_count),   32'd0);
        chk("rst_pc",     32'(pkt_count),    32'd0);
        chk("rst_busy",   32'(busy),         32'd0);
        PresetFull = 1'b0;

        // Empty FIFO: nothing happens
        enable = 1'b1;
        s0 = slwr_cnt; r0 = rdreq_cnt;
        repeat (100) @(negedge rdclk);
        #1;
        chk("empty_rdreq", 32'(rdreq_cnt), 32'(r0));
        chk("empty_slwr",  32'(slwr_cnt),  32'(s0));

        // Single byte closed by idle timeout
        s0 = slwr_cnt; r0 = rdreq_cnt; p0 = pktend_cnt;
        push(8'hA5);
        wait_cnt("single_slwr_seen", 0, s0 + 1, 20);
        wait_cnt("single_pktend_seen", 1, p0 + 1, 40);
        repeat (5) @(negedge rdclk);
        #1;
        gap = pktend_cyc - log_cyc[s0 % 64];
        chk("single_fd",        32'(log_fd[s0 % 64]), 32'hA5);
        chk("single_rdreq",     32'(rdreq_cnt),  32'(r0 + 1));
        chk("single_slwr_cnt",  32'(slwr_cnt),   32'(s0 + 1));
        chk("single_pktend",    32'(pktend_cnt), 32'(p0 + 1));
        chk("single_gap_min",   32'(gap >= int'(TIMEOUT_CYCLES)), 32'd1);
        chk("single_gap_max",   32'(gap <= int'(TIMEOUT_CYCLES) + 3), 32'd1);
        chk("single_pc",        32'(pkt_count),  32'd1);
        chk("single_bc",        32'(byte_count), 32'd0);

        // Endpoint full while strobing 0x3C
        s0 = slwr_cnt; r0 = rdreq_cnt; p0 = pktend_cnt;
        push(8'h3C);
        wait_cnt("stall_rdreq_seen", 2, r0 + 1, 20);
        fx2_full_n = 1'b0;
        @(negedge rdclk);
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge rdclk);
            if ((fx2_fd !== 8'h3C) || (fx2_slwr_n !== 1'b1)) held_ok = 1'b0;
        end
        #1;
        chk("stall_held",      32'(held_ok),  32'd1);
        chk("stall_no_slwr",   32'(slwr_cnt), 32'(s0));
        fx2_full_n = 1'b1;
        wait_cnt("stall_slwr_seen", 0, s0 + 1, 10);
        wait_cnt("stall_pktend_seen", 1, p0 + 1, 40);
        repeat (5) @(negedge rdclk);
        #1;
        chk("stall_fd",        32'(log_fd[s0 % 64]), 32'h3C);
        chk("stall_slwr_cnt",  32'(slwr_cnt),  32'(s0 + 1));
        chk("stall_pc",        32'(pkt_count), 32'd2);

        // Table: full packet then two bytes, then disable flushes the short packet
        s0 = slwr_cnt; p0 = pktend_cnt;
        for (int i = 0; i < 6; i++) push(vecs[i].data);
        for (int i = 0; i < 6; i++) begin
            wait_cnt($sformatf("vec%0d_seen", i), 0, s0 + i + 1, 20);
            chk($sformatf("vec%0d_fd", i), 32'(log_fd[(s0 + i) % 64]), 32'(vecs[i].data));
            chk($sformatf("vec%0d_bc", i), 32'(log_bc[(s0 + i) % 64]), 32'(vecs[i].exp_bc));
            chk($sformatf("vec%0d_pc", i), 32'(log_pc[(s0 + i) % 64]), 32'(vecs[i].exp_pc));
        end
        chk("vec_no_pktend", 32'(pktend_cnt), 32'(p0));
        enable = 1'b0;
        r0 = rdreq_cnt;
        push(8'h77);
        wait_cnt("dis_pktend_seen", 1, p0 + 1, 20);
        repeat (20) @(negedge rdclk);
        #1;
        chk("dis_pktend_once", 32'(pktend_cnt), 32'(p0 + 1));
        chk("dis_no_rdreq",    32'(rdreq_cnt),  32'(r0));
        chk("dis_pc",          32'(pkt_count),  32'd4);
        chk("dis_bc",          32'(byte_count), 32'd0);

        // Reset while stalled in STROBE of the second byte of a packet
        s0 = slwr_cnt; r0 = rdreq_cnt; p0 = pktend_cnt;
        push(8'h11);
        enable = 1'b1;
        wait_cnt("rst_fetch2_seen", 2, r0 + 2, 30);
        fx2_full_n = 1'b0;
        repeat (4) @(negedge rdclk);
        chk("midrst_busy_pre", 32'(busy),       32'd1);
        chk("midrst_bc_pre",   32'(byte_count), 32'd1);
        #2;
        PresetFull = 1'b1;
        #1;
        chk("midrst_slwr",  32'(fx2_slwr_n), 32'd1);
        chk("midrst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("midrst_bc",    32'(byte_count), 32'd0);
        chk("midrst_busy",  32'(busy),       32'd0);
        @(negedge rdclk);
        PresetFull = 1'b0;
        fx2_full_n = 1'b1;
        repeat (30) @(negedge rdclk);
        #1;
        chk("midrst_slwr_cnt", 32'(slwr_cnt),   32'(s0 + 1));
        chk("midrst_pktend",   32'(pktend_cnt), 32'(p0));
        chk("midrst_pc",       32'(pkt_count),  32'd0);
        chk("bad_rdreq",       32'(bad_rdreq),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
